adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter OVF_CNT_W, default 8, width of the saturating overflow counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports in0_valid/in1_valid  input  1  requester 0/1 offers an operation.
REQ-005 SHALL have ports in0_ready/in1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-006 SHALL have ports in0_a, in0_b, in1_a, in1_b  input  32  signed operands per requester.
REQ-007 SHALL have ports in0_op/in1_op  input  1  0 = a+b, 1 = a-b.
REQ-008 SHALL have port out_valid  output  1  result register holds an unconsumed result.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_sum  output  32  signed result, two's-complement wrap.
REQ-011 SHALL have port out_overflow  output  1  signed overflow of the result.
REQ-012 SHALL have port out_tag  output  1  index of requester that produced the result.
REQ-013 SHALL have port ovf_count  output  OVF_CNT_W  saturating count of overflowing results issued.
REQ-014 SHALL have port ovf_clear  input  1  synchronous clear of ovf_count.

Function
REQ-015 SHALL hold one result register with states EMPTY and FULL; out_valid = (state == FULL).
REQ-016 Slot free SHALL be defined as state EMPTY, or state FULL with out_ready high.
REQ-017 Grant SHALL occur only when slot free and at least one inX_valid is high; at most one inX_ready high per cycle.
REQ-018 inX_ready SHALL be combinational: high only for the granted requester; never high when its inX_valid is low.
REQ-019 Only one requester valid SHALL be granted regardless of priority pointer.
REQ-020 Both valid SHALL grant the requester named by a 1-bit round-robin pointer; after any grant the pointer SHALL point to the other requester.
REQ-021 On grant, result SHALL be registered same edge: out_valid high next cycle (latency 1), out_tag = granted index.
REQ-022 Add: out_sum = a+b mod 2^32; out_overflow = 1 iff a,b same sign and sum sign differs.
REQ-023 Sub: out_sum = a-b mod 2^32; out_overflow = 1 iff a,b differ in sign and result sign differs from a (covers b = 0x80000000).
REQ-024 FULL with out_ready high and a new grant SHALL replace the result same edge, staying FULL (back-to-back throughput 1/cycle).
REQ-025 FULL with out_ready high and no grant SHALL go EMPTY; FULL with out_ready low SHALL hold out_sum, out_overflow, out_tag stable.
REQ-026 ovf_count SHALL increment on each grant whose result overflows, saturating at all-ones.
REQ-027 ovf_clear high SHALL zero ovf_count, taking priority over a same-cycle increment.
REQ-028 Operands SHALL be sampled only in the grant cycle; later changes to inX_a/b/op SHALL not affect the stored result.

Reset
REQ-029 rst_n low SHALL asynchronously force state EMPTY, out_valid 0, out_sum 0, out_overflow 0, out_tag 0, ovf_count 0, pointer = requester 0.
REQ-030 While rst_n low, in0_ready and in1_ready SHALL be 0; a result pending at reset SHALL be discarded.
REQ-031 First grant after rst_n rises SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-032 in0 only, a=10, b=5, op=0 -> in0_ready=1; next cycle out_valid=1, out_sum=15, out_overflow=0, out_tag=0.
REQ-033 in1 only, a=0x7FFFFFFF, b=1, op=0 -> out_sum=0x80000000, out_overflow=1, ovf_count=1; then ovf_clear -> ovf_count=0.
REQ-034 in0 op=1 a=0, b=0x80000000 -> out_sum=0x80000000, out_overflow=1; a=-10, b=5, op=1 -> out_sum=-15, overflow 0.
REQ-035 Both valid continuously, out_ready=1, after reset -> grants alternate 0,1,0,1; out_tag follows; one result per cycle.
REQ-036 out_ready=0 with result held, both valid -> in0_ready=in1_ready=0, output stable; raise out_ready -> next grant same cycle.
REQ-037 Assert rst_n low while out_valid=1 -> out_valid drops immediately (before next edge), all outputs 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester add/subtract unit with a single-entry result register.
// A 1-bit round-robin pointer picks between requesters when both offer an
// operation. The result slot may be refilled in the same cycle its current
// contents are consumed. Signed overflows of issued results are counted in a
// saturating counter.
module adder_arbiter #(
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [31:0]          in0_a,
  input  logic [31:0]          in0_b,
  input  logic                 in0_op,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic [31:0]          in1_a,
  input  logic [31:0]          in1_b,
  input  logic                 in1_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_sum,
  output logic                 out_overflow,
  output logic                 out_tag,
  output logic [OVF_CNT_W-1:0] ovf_count,
  input  logic                 ovf_clear
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  logic        ptr;        // requester that wins when both are valid
  logic        slot_free;
  logic        grant0;
  logic        grant1;
  logic        grant;
  logic        sel_tag;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic        sel_op;
  logic [31:0] res;
  logic        res_ovf;

  assign out_valid = (state == FULL);

  // Arbitration: the slot is free when empty or being drained this cycle.
  // Grants are held off while reset is asserted so the first one can only
  // land on the first rising edge after release.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    slot_free = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    slot_free = (state == EMPTY) || out_ready;
    if (rst_n && slot_free) begin
      grant0 = in0_valid && (!in1_valid || (ptr == 1'b0));
      grant1 = in1_valid && (!in0_valid || (ptr == 1'b1));
    end
  end

  assign in0_ready = grant0;
  assign in1_ready = grant1;
  assign grant     = grant0 || grant1;
  assign sel_tag   = grant1;

  // Operand mux and arithmetic for the granted requester.
  always_comb begin
    sel_a   = in0_a;
    sel_b   = in0_b;
    sel_op  = in0_op;
    res     = '0;
    res_ovf = 1'b0;
    if (sel_tag) begin
      sel_a  = in1_a;
      sel_b  = in1_b;
      sel_op = in1_op;
    end
    if (sel_op) begin
      res     = sel_a - sel_b;
      // Subtraction overflows only when operands differ in sign and the
      // result sign moves away from a; this also covers b = most-negative.
      res_ovf = (sel_a[31] != sel_b[31]) && (res[31] != sel_a[31]);
    end else begin
      res     = sel_a + sel_b;
      res_ovf = (sel_a[31] == sel_b[31]) && (res[31] != sel_a[31]);
    end
  end

  // Result register: load on grant (also when draining), empty on drain
  // without a new grant, otherwise hold.
  // NOTE: asynchronous active-low reset lives in the sensitivity list so the
  // outputs clear immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      out_sum      <= '0;
      out_overflow <= 1'b0;
      out_tag      <= 1'b0;
      ptr          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, so ordering inside the block cannot matter.
      if (grant) begin
        state        <= FULL;
        out_sum      <= res;
        out_overflow <= res_ovf;
        out_tag      <= sel_tag;
        ptr          <= ~sel_tag;
      end else if (out_ready) begin
        state <= EMPTY;
      end
    end
  end

  // Saturating overflow counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clear) begin
      ovf_count <= '0;
    end else if (grant && res_ovf && (ovf_count != {OVF_CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter. A negedge monitor keeps a reference
// model of slot state, round-robin pointer and overflow count, pushes the
// expected result for each modelled grant and pops it when the result is
// consumed. Scenario tasks add directed value checks.
module tb_adder_arbiter;

  logic        clk;
  logic        rst_n;
  logic        in0_valid, in1_valid;
  logic        in0_ready, in1_ready;
  logic [31:0] in0_a, in0_b, in1_a, in1_b;
  logic        in0_op, in1_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_overflow;
  logic        out_tag;
  logic [7:0]  ovf_count;
  logic        ovf_clear;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
    logic        tag;
  } exp_t;

  exp_t q[$];

  // Reference model state.
  logic       m_full;
  logic       m_ptr;
  logic [7:0] m_cnt;

  adder_arbiter #(.OVF_CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in0_valid   (in0_valid),
    .in0_ready   (in0_ready),
    .in0_a       (in0_a),
    .in0_b       (in0_b),
    .in0_op      (in0_op),
    .in1_valid   (in1_valid),
    .in1_ready   (in1_ready),
    .in1_a       (in1_a),
    .in1_b       (in1_b),
    .in1_op      (in1_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_overflow(out_overflow),
    .out_tag     (out_tag),
    .ovf_count   (ovf_count),
    .ovf_clear   (ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wide signed arithmetic: overflow is simply "result outside int32 range".
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic op);
    longint wa, wb, r;
    logic   o;
    wa = longint'($signed(a));
    wb = longint'($signed(b));
    r  = op ? (wa - wb) : (wa + wb);
    o  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {o, r[31:0]};
  endfunction

  // Monitor: compare DUT handshake/state to the model, score consumed results.
  always @(negedge clk) begin
    logic        free, g0, g1;
    logic [32:0] r;
    exp_t        e;
    if (!rst_n) begin
      q.delete();
      m_full = 1'b0;
      m_ptr  = 1'b0;
      m_cnt  = 8'd0;
      total++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: ready0=%b ready1=%b valid=%b want 0 0 0",
                 in0_ready, in1_ready, out_valid);
      end
    end else begin
      total++;
      if (out_valid !== m_full) begin
        bad++;
        $display("FAIL out_valid: got %b want %b", out_valid, m_full);
      end
      total++;
      if (ovf_count !== m_cnt) begin
        bad++;
        $display("FAIL ovf_count: got %0d want %0d", ovf_count, m_cnt);
      end
      free = !m_full || out_ready;
      g0   = free && in0_valid && (!in1_valid || !m_ptr);
      g1   = free && in1_valid && (!in0_valid || m_ptr);
      total++;
      if (in0_ready !== g0 || in1_ready !== g1) begin
        bad++;
        $display("FAIL grant: got r0=%b r1=%b want r0=%b r1=%b", in0_ready, in1_ready, g0, g1);
      end
      if (m_full && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty: got result %h with nothing expected", out_sum);
        end else begin
          e = q.pop_front();
          if (out_sum !== e.sum || out_overflow !== e.ovf || out_tag !== e.tag) begin
            bad++;
            $display("FAIL result: got sum=%h ovf=%b tag=%b want sum=%h ovf=%b tag=%b",
                     out_sum, out_overflow, out_tag, e.sum, e.ovf, e.tag);
          end
        end
      end
      r = 33'd0;
      if (g0 || g1) begin
        r     = g1 ? model(in1_a, in1_b, in1_op) : model(in0_a, in0_b, in0_op);
        e.sum = r[31:0];
        e.ovf = r[32];
        e.tag = g1;
        q.push_back(e);
        m_full = 1'b1;
        m_ptr  = ~g1;
      end else if (m_full && out_ready) begin
        m_full = 1'b0;
      end
      if (ovf_clear)                          m_cnt = 8'd0;
      else if ((g0 || g1) && r[32] && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    out_ready = 1'b1;
    ovf_clear = 1'b0;
    tick();
    tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_overflow !== 1'b0 ||
        out_tag !== 1'b0 || ovf_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_values: got v=%b s=%h o=%b t=%b c=%0d want all 0",
               out_valid, out_sum, out_overflow, out_tag, ovf_count);
    end
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    in0_valid = 1'b1; in0_a = 32'd10; in0_b = 32'd5; in0_op = 1'b0;
    @(negedge clk);
    total++;
    if (in0_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_ready: got %b want 1", in0_ready);
    end
    tick();
    in0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_sum !== 32'd15 || out_overflow !== 1'b0 || out_tag !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got v=%b s=%0d o=%b t=%b want 1 15 0 0",
               out_valid, out_sum, out_overflow, out_tag);
    end
    idle();
  endtask

  task automatic test_add_overflow();
    in1_valid = 1'b1; in1_a = 32'h7FFF_FFFF; in1_b = 32'd1; in1_op = 1'b0;
    tick();
    in1_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_sum !== 32'h8000_0000 || out_overflow !== 1'b1 || out_tag !== 1'b1 ||
        ovf_count !== 8'd1) begin
      bad++;
      $display("FAIL add_ovf: got s=%h o=%b t=%b c=%0d want 80000000 1 1 1",
               out_sum, out_overflow, out_tag, ovf_count);
    end
    tick();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    @(negedge clk);
    total++;
    if (ovf_count !== 8'd0) begin
      bad++;
      $display("FAIL ovf_clear: got %0d want 0", ovf_count);
    end
    idle();
  endtask

  task automatic test_sub();
    in0_valid = 1'b1; in0_a = 32'd0; in0_b = 32'h8000_0000; in0_op = 1'b1;
    tick();
    in0_a = -32'sd10; in0_b = 32'd5;
    @(negedge clk);
    total++;
    if (out_sum !== 32'h8000_0000 || out_overflow !== 1'b1) begin
      bad++;
      $display("FAIL sub_minneg: got s=%h o=%b want 80000000 1", out_sum, out_overflow);
    end
    tick();
    in0_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_sum !== 32'hFFFF_FFF1 || out_overflow !== 1'b0) begin
      bad++;
      $display("FAIL sub_neg: got s=%h o=%b want fffffff1 0", out_sum, out_overflow);
    end
    idle();
  endtask

  task automatic test_alternate();
    apply_reset();
    in0_valid = 1'b1; in0_a = 32'd1; in0_b = 32'd2; in0_op = 1'b0;
    in1_valid = 1'b1; in1_a = 32'd7; in1_b = 32'd3; in1_op = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (in0_ready !== (i % 2 == 0) || in1_ready !== (i % 2 == 1)) begin
        bad++;
        $display("FAIL alternate_grant[%0d]: got r0=%b r1=%b want r0=%b r1=%b",
                 i, in0_ready, in1_ready, (i % 2 == 0), (i % 2 == 1));
      end
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_tag !== ((i - 1) % 2 == 1)) begin
          bad++;
          $display("FAIL alternate_tag[%0d]: got v=%b t=%b want 1 %b",
                   i, out_valid, out_tag, ((i - 1) % 2 == 1));
        end
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_a = 32'd100; in0_b = 32'd1; in0_op = 1'b0;
    in1_a = 32'd5; in1_b = 32'd5; in1_op = 1'b0;
    @(negedge clk);
    total++;
    if (in0_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_first_grant: got %b want 1", in0_ready);
    end
    tick();
    in0_a = 32'd999; in0_op = 1'b1;
    in1_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_sum !== 32'd101 || out_tag !== 1'b0 || out_overflow !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got r0=%b r1=%b v=%b s=%0d t=%b want 0 0 1 101 0",
                 k, in0_ready, in1_ready, out_valid, out_sum, out_tag);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got r0=%b r1=%b want 0 1", in0_ready, in1_ready);
    end
    tick();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    idle();
  endtask

  task automatic test_saturate();
    ovf_clear = 1'b1;
    in0_valid = 1'b1; in0_a = 32'h7FFF_FFFF; in0_b = 32'd1; in0_op = 1'b0;
    out_ready = 1'b1;
    tick();
    ovf_clear = 1'b0;
    repeat (260) tick();
    @(negedge clk);
    total++;
    if (ovf_count !== 8'hFF) begin
      bad++;
      $display("FAIL saturate: got %0d want 255", ovf_count);
    end
    tick();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    @(negedge clk);
    total++;
    if (ovf_count !== 8'd0) begin
      bad++;
      $display("FAIL clear_priority: got %0d want 0", ovf_count);
    end
    @(negedge clk);
    total++;
    if (ovf_count !== 8'd1) begin
      bad++;
      $display("FAIL count_after_clear: got %0d want 1", ovf_count);
    end
    in0_valid = 1'b0;
    idle();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'd0;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in0_valid = ($urandom_range(0, 3) != 0);
      in1_valid = ($urandom_range(0, 3) != 0);
      in0_a = pick_operand(); in0_b = pick_operand(); in0_op = $urandom_range(0, 1) == 1;
      in1_a = pick_operand(); in1_b = pick_operand(); in1_op = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clear = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in0_valid = 1'b1; in0_a = 32'h7FFF_FFFF; in0_b = 32'd4; in0_op = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre: got v=%b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_overflow !== 1'b0 ||
        out_tag !== 1'b0 || ovf_count !== 8'd0 || in0_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got v=%b s=%h o=%b t=%b c=%0d r0=%b want all 0",
               out_valid, out_sum, out_overflow, out_tag, ovf_count, in0_ready);
    end
    tick();
    tick();
    in0_valid = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_discard: got v=%b want 0", out_valid);
    end
    idle();
  endtask

  task automatic test_drain();
    idle();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d results outstanding want 0", q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_a = '0; in0_b = '0; in0_op = 1'b0;
    in1_a = '0; in1_b = '0; in1_op = 1'b0;
    out_ready = 1'b1;
    ovf_clear = 1'b0;
    test_reset();
    test_basic();
    test_add_overflow();
    test_sub();
    test_alternate();
    test_backpressure();
    test_saturate();
    test_random();
    test_reset_mid();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
